// File: rtl/axi_lite_pkg.sv
// Shared AXI-lite types for register-file style slaves.
//   axi_resp_t     : 2-bit response code plus the four standard constants.
//   write_state_t  : write channel FSM states (W_IDLE, W_RESP).
//   read_state_t   : read channel FSM states (R_IDLE, R_DATA).
package axi_lite_pkg;

  typedef logic [1:0] axi_resp_t;

  localparam axi_resp_t RESP_OKAY   = 2'b00;
  localparam axi_resp_t RESP_EXOKAY = 2'b01;
  localparam axi_resp_t RESP_SLVERR = 2'b10;
  localparam axi_resp_t RESP_DECERR = 2'b11;

  typedef enum logic {W_IDLE, W_RESP} write_state_t;
  typedef enum logic {R_IDLE, R_DATA} read_state_t;

endpackage

// File: rtl/axi_lite_interface.sv
// AXI-lite bundle with Master and Slave views.
//   Parameters: READ_ADDRESS_WIDTH, WRITE_ADDRESS_WIDTH, DATA_WIDTH.
//   Channels: AW (awaddr/awprot/awvalid/awready), W (wdata/wstrb/wvalid/wready),
//             B (bresp/bvalid/bready), AR (araddr/arprot/arvalid/arready),
//             R (rdata/rresp/rvalid/rready).
interface axi_lite_interface #(
  parameter int READ_ADDRESS_WIDTH  = 8,
  parameter int WRITE_ADDRESS_WIDTH = 8,
  parameter int DATA_WIDTH          = 32
);
  logic [WRITE_ADDRESS_WIDTH-1:0] awaddr;
  logic [2:0]                     awprot;
  logic                           awvalid;
  logic                           awready;
  logic [DATA_WIDTH-1:0]          wdata;
  logic [DATA_WIDTH/8-1:0]        wstrb;
  logic                           wvalid;
  logic                           wready;
  logic [1:0]                     bresp;
  logic                           bvalid;
  logic                           bready;
  logic [READ_ADDRESS_WIDTH-1:0]  araddr;
  logic [2:0]                     arprot;
  logic                           arvalid;
  logic                           arready;
  logic [DATA_WIDTH-1:0]          rdata;
  logic [1:0]                     rresp;
  logic                           rvalid;
  logic                           rready;

  modport Slave (
    input  awaddr, awprot, awvalid, output awready,
    input  wdata, wstrb, wvalid,    output wready,
    output bresp, bvalid,           input  bready,
    input  araddr, arprot, arvalid, output arready,
    output rdata, rresp, rvalid,    input  rready
  );

  modport Master (
    output awaddr, awprot, awvalid, input  awready,
    output wdata, wstrb, wvalid,    input  wready,
    input  bresp, bvalid,           output bready,
    output araddr, arprot, arvalid, input  arready,
    input  rdata, rresp, rvalid,    output rready
  );
endinterface

// File: rtl/axi_lite_strobe_merge.sv
// Byte-lane write merge: lanes with i_wstrb set take i_wdata, others keep i_old.
//   i_old    : current register word
//   i_wdata  : write data
//   i_wstrb  : byte strobes, one per 8 bits
//   o_merged : resulting word
module axi_lite_strobe_merge #(
  parameter int DATA_WIDTH = 32
) (
  input  logic [DATA_WIDTH-1:0]   i_old,
  input  logic [DATA_WIDTH-1:0]   i_wdata,
  input  logic [DATA_WIDTH/8-1:0] i_wstrb,
  output logic [DATA_WIDTH-1:0]   o_merged
);
  always_comb begin
    o_merged = i_old;
    for (int unsigned b = 0; b < DATA_WIDTH/8; b++) begin
      if (i_wstrb[b]) o_merged[b*8 +: 8] = i_wdata[b*8 +: 8];
    end
  end
endmodule

// File: rtl/axi_lite_register_file.sv
// AXI-lite slave register file.
//   NUM_RW control registers (word index 0..NUM_RW-1) driven on ctrl_out,
//   NUM_RO status registers (word index NUM_RW..NUM_RW+NUM_RO-1) read from status_in.
//   One outstanding write and one outstanding read, channels independent.
// Ports:
//   clk, reset      : clock, synchronous active-high reset
//   bus             : axi_lite_interface.Slave
//   ctrl_out        : flattened RW registers, reg i at [i*DATA_WIDTH +: DATA_WIDTH]
//   status_in       : flattened RO values, sampled at the AR handshake
//   ctrl_wr_pulse   : (only with AXI_LITE_REGFILE_WRITE_PULSE_EN) one-cycle pulse per
//                     RW register in the cycle its ctrl_out value updates
module axi_lite_register_file
  import axi_lite_pkg::*;
#(
  parameter int ADDR_WIDTH = 8,
  parameter int DATA_WIDTH = 32,
  parameter int NUM_RW     = 4,
  parameter int NUM_RO     = 4
) (
  input  logic                         clk,
  input  logic                         reset,
  axi_lite_interface.Slave             bus,
  output logic [NUM_RW*DATA_WIDTH-1:0] ctrl_out,
  input  logic [NUM_RO*DATA_WIDTH-1:0] status_in
`ifdef AXI_LITE_REGFILE_WRITE_PULSE_EN
  ,
  output logic [NUM_RW-1:0]            ctrl_wr_pulse
`endif
);
  localparam int STRB_W   = DATA_WIDTH/8;
  localparam int ADDR_LSB = $clog2(STRB_W);
  localparam int IW       = ADDR_WIDTH - ADDR_LSB;

  // Readies come up one cycle after reset is released.
  logic r_rdy_en;

  write_state_t          r_wstate;
  logic                  r_aw_full;
  logic [ADDR_WIDTH-1:0] r_aw_addr;
  logic                  r_w_full;
  logic [DATA_WIDTH-1:0] r_w_data;
  logic [STRB_W-1:0]     r_w_strb;
  axi_resp_t             r_bresp;
  logic [DATA_WIDTH-1:0] r_ctrl [NUM_RW];

  read_state_t           r_rstate;
  logic [DATA_WIDTH-1:0] r_rdata;
  axi_resp_t             r_rresp;

  logic                  w_awready, w_wready, w_arready;
  logic                  w_aw_hs, w_w_hs, w_ar_hs, w_commit;
  logic [ADDR_WIDTH-1:0] w_wr_addr;
  logic [DATA_WIDTH-1:0] w_wr_data, w_wr_old, w_merged, w_rd_data;
  logic [STRB_W-1:0]     w_wr_strb;
  logic [IW-1:0]         w_wr_idx, w_rd_idx;
  axi_resp_t             w_wr_resp, w_rd_resp;
  logic                  w_unused;

  assign w_awready = r_rdy_en && !r_aw_full && (r_wstate == W_IDLE);
  assign w_wready  = r_rdy_en && !r_w_full  && (r_wstate == W_IDLE);
  assign w_arready = r_rdy_en && (r_rstate == R_IDLE);
  assign w_aw_hs   = bus.awvalid && w_awready;
  assign w_w_hs    = bus.wvalid  && w_wready;
  assign w_ar_hs   = bus.arvalid && w_arready;

  // Each half comes from its buffer if already captured, else straight off the bus,
  // so a same-cycle AW+W pair commits without a buffering cycle.
  assign w_wr_addr = r_aw_full ? r_aw_addr : bus.awaddr;
  assign w_wr_data = r_w_full  ? r_w_data  : bus.wdata;
  assign w_wr_strb = r_w_full  ? r_w_strb  : bus.wstrb;
  assign w_commit  = (r_wstate == W_IDLE) && (r_aw_full || w_aw_hs) && (r_w_full || w_w_hs);

  assign w_wr_idx  = w_wr_addr[ADDR_WIDTH-1:ADDR_LSB];
  assign w_rd_idx  = bus.araddr[ADDR_WIDTH-1:ADDR_LSB];
  assign w_unused  = ^{bus.awprot, bus.arprot, w_wr_addr[ADDR_LSB-1:0], bus.araddr[ADDR_LSB-1:0]};

  always_comb begin
    w_wr_resp = RESP_DECERR;
    w_wr_old  = '0;
    for (int unsigned i = 0; i < NUM_RW; i++) begin
      if (w_wr_idx == IW'(i)) begin
        w_wr_resp = RESP_OKAY;
        w_wr_old  = r_ctrl[i];
      end
    end
    for (int unsigned j = 0; j < NUM_RO; j++) begin
      if (w_wr_idx == IW'(NUM_RW + j)) w_wr_resp = RESP_SLVERR;
    end
  end

  always_comb begin
    w_rd_data = '0;
    w_rd_resp = RESP_DECERR;
    for (int unsigned i = 0; i < NUM_RW; i++) begin
      if (w_rd_idx == IW'(i)) begin
        w_rd_data = r_ctrl[i];
        w_rd_resp = RESP_OKAY;
      end
    end
    for (int unsigned j = 0; j < NUM_RO; j++) begin
      if (w_rd_idx == IW'(NUM_RW + j)) begin
        w_rd_data = status_in[j*DATA_WIDTH +: DATA_WIDTH];
        w_rd_resp = RESP_OKAY;
      end
    end
  end

  axi_lite_strobe_merge #(.DATA_WIDTH(DATA_WIDTH)) u_merge (
    .i_old    (w_wr_old),
    .i_wdata  (w_wr_data),
    .i_wstrb  (w_wr_strb),
    .o_merged (w_merged)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      r_rdy_en  <= 1'b0;
      r_wstate  <= W_IDLE;
      r_aw_full <= 1'b0;
      r_aw_addr <= '0;
      r_w_full  <= 1'b0;
      r_w_data  <= '0;
      r_w_strb  <= '0;
      r_bresp   <= RESP_OKAY;
      for (int unsigned i = 0; i < NUM_RW; i++) r_ctrl[i] <= '0;
    end else begin
      r_rdy_en <= 1'b1;
      case (r_wstate)
        W_IDLE: begin
          if (w_aw_hs) begin
            r_aw_full <= 1'b1;
            r_aw_addr <= bus.awaddr;
          end
          if (w_w_hs) begin
            r_w_full <= 1'b1;
            r_w_data <= bus.wdata;
            r_w_strb <= bus.wstrb;
          end
          if (w_commit) begin
            r_wstate <= W_RESP;
            r_bresp  <= w_wr_resp;
            // An index match here can only be an RW register.
            for (int unsigned i = 0; i < NUM_RW; i++) begin
              if (w_wr_idx == IW'(i)) r_ctrl[i] <= w_merged;
            end
          end
        end
        W_RESP: begin
          if (bus.bready) begin
            r_wstate  <= W_IDLE;
            r_aw_full <= 1'b0;
            r_w_full  <= 1'b0;
          end
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_rstate <= R_IDLE;
      r_rdata  <= '0;
      r_rresp  <= RESP_OKAY;
    end else begin
      case (r_rstate)
        R_IDLE: begin
          if (w_ar_hs) begin
            r_rdata  <= w_rd_data;
            r_rresp  <= w_rd_resp;
            r_rstate <= R_DATA;
          end
        end
        R_DATA: begin
          if (bus.rready) r_rstate <= R_IDLE;
        end
      endcase
    end
  end

`ifdef AXI_LITE_REGFILE_WRITE_PULSE_EN
  logic [NUM_RW-1:0] r_wr_pulse;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_wr_pulse <= '0;
    end else begin
      for (int unsigned i = 0; i < NUM_RW; i++) begin
        r_wr_pulse[i] <= w_commit && (w_wr_idx == IW'(i));
      end
    end
  end

  assign ctrl_wr_pulse = r_wr_pulse;
`endif

  for (genvar g = 0; g < NUM_RW; g++) begin : g_ctrl
    assign ctrl_out[g*DATA_WIDTH +: DATA_WIDTH] = r_ctrl[g];
  end

  assign bus.awready = w_awready;
  assign bus.wready  = w_wready;
  assign bus.bvalid  = (r_wstate == W_RESP);
  assign bus.bresp   = r_bresp;
  assign bus.arready = w_arready;
  assign bus.rvalid  = (r_rstate == R_DATA);
  assign bus.rdata   = r_rdata;
  assign bus.rresp   = r_rresp;

endmodule

// File: tb/tb_axi_lite_register_file.sv
module tb_axi_lite_register_file;
  logic         clk = 1'b0;
  logic         reset;
  logic [127:0] ctrl_out;
  logic [127:0] status_in;
`ifdef AXI_LITE_REGFILE_WRITE_PULSE_EN
  logic [3:0]   ctrl_wr_pulse;
`endif

  always #5 clk = ~clk;

  axi_lite_interface #(.READ_ADDRESS_WIDTH(8), .WRITE_ADDRESS_WIDTH(8), .DATA_WIDTH(32)) bus_if ();

  axi_lite_register_file #(.ADDR_WIDTH(8), .DATA_WIDTH(32), .NUM_RW(4), .NUM_RO(4)) dut (
    .clk       (clk),
    .reset     (reset),
    .bus       (bus_if),
    .ctrl_out  (ctrl_out),
    .status_in (status_in)
`ifdef AXI_LITE_REGFILE_WRITE_PULSE_EN
    ,
    .ctrl_wr_pulse (ctrl_wr_pulse)
`endif
  );

  int n_cmp = 0;
  int n_err = 0;

  typedef struct {
    bit          wr;
    logic [7:0]  addr;
    logic [31:0] data;
    logic [3:0]  strb;
    logic [1:0]  resp;
    logic [31:0] rdata;
  } vec_t;

  vec_t tbl [15];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [31:0] reg_of(input int i);
    return ctrl_out[i*32 +: 32];
  endfunction

  task automatic do_write(input logic [7:0] a, input logic [31:0] d, input logic [3:0] s,
                          output logic [1:0] resp);
    int g;
    bus_if.awaddr  = a;
    bus_if.wdata   = d;
    bus_if.wstrb   = s;
    bus_if.awvalid = 1'b1;
    bus_if.wvalid  = 1'b1;
    g = 0;
    while (!(bus_if.awready && bus_if.wready) && g < 20) begin
      tick();
      g++;
    end
    check("wr_readies", {bus_if.awready, bus_if.wready}, 2'b11);
    tick();
    bus_if.awvalid = 1'b0;
    bus_if.wvalid  = 1'b0;
    check("wr_bvalid_latency", bus_if.bvalid, 1'b1);
    resp = bus_if.bresp;
    bus_if.bready = 1'b1;
    tick();
    bus_if.bready = 1'b0;
    check("wr_bvalid_clear", bus_if.bvalid, 1'b0);
  endtask

  task automatic do_read(input logic [7:0] a, output logic [31:0] d, output logic [1:0] resp);
    int g;
    bus_if.araddr  = a;
    bus_if.arvalid = 1'b1;
    g = 0;
    while (!bus_if.arready && g < 20) begin
      tick();
      g++;
    end
    check("rd_arready", bus_if.arready, 1'b1);
    tick();
    bus_if.arvalid = 1'b0;
    check("rd_rvalid_latency", bus_if.rvalid, 1'b1);
    d    = bus_if.rdata;
    resp = bus_if.rresp;
    bus_if.rready = 1'b1;
    tick();
    bus_if.rready = 1'b0;
    check("rd_rvalid_clear", bus_if.rvalid, 1'b0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [1:0]  r;
    logic [31:0] d;

    bus_if.awaddr = '0; bus_if.awprot = '0; bus_if.awvalid = 1'b0;
    bus_if.wdata  = '0; bus_if.wstrb  = '0; bus_if.wvalid  = 1'b0;
    bus_if.bready = 1'b0;
    bus_if.araddr = '0; bus_if.arprot = '0; bus_if.arvalid = 1'b0;
    bus_if.rready = 1'b0;
    status_in = {32'hFFFF0000, 32'h00000066, 32'h5A5A0001, 32'h0000CAFE};

    //            wr    addr   data          strb  resp   rdata
    tbl[0]  = '{1'b1, 8'h04, 32'hDEADBEEF, 4'hF, 2'b00, 32'h0};
    tbl[1]  = '{1'b0, 8'h04, 32'h0,        4'h0, 2'b00, 32'hDEADBEEF};
    tbl[2]  = '{1'b0, 8'h10, 32'h0,        4'h0, 2'b00, 32'h0000CAFE};
    tbl[3]  = '{1'b1, 8'h10, 32'h12345678, 4'hF, 2'b10, 32'h0};
    tbl[4]  = '{1'b0, 8'h10, 32'h0,        4'h0, 2'b00, 32'h0000CAFE};
    tbl[5]  = '{1'b0, 8'h40, 32'h0,        4'h0, 2'b11, 32'h0};
    tbl[6]  = '{1'b1, 8'h40, 32'h12345678, 4'hF, 2'b11, 32'h0};
    tbl[7]  = '{1'b1, 8'h08, 32'hFFFFFFFF, 4'h0, 2'b00, 32'h0};
    tbl[8]  = '{1'b0, 8'h08, 32'h0,        4'h0, 2'b00, 32'h0};
    tbl[9]  = '{1'b0, 8'h1C, 32'h0,        4'h0, 2'b00, 32'hFFFF0000};
    tbl[10] = '{1'b0, 8'h20, 32'h0,        4'h0, 2'b11, 32'h0};
    tbl[11] = '{1'b1, 8'h0C, 32'hCAFEF00D, 4'hC, 2'b00, 32'h0};
    tbl[12] = '{1'b0, 8'h0E, 32'h0,        4'h0, 2'b00, 32'hCAFE0000};
    tbl[13] = '{1'b0, 8'h17, 32'h0,        4'h0, 2'b00, 32'h5A5A0001};
    tbl[14] = '{1'b1, 8'h00, 32'h11223344, 4'hF, 2'b00, 32'h0};

    // Reset state
    reset = 1'b1;
    tick(); tick(); tick();
    check("rst_readies", {bus_if.awready, bus_if.wready, bus_if.arready}, 3'b000);
    check("rst_valids", {bus_if.bvalid, bus_if.rvalid}, 2'b00);
    check("rst_resps", {bus_if.bresp, bus_if.rresp}, 4'b0000);
    check("rst_rdata", bus_if.rdata, 32'h0);
    check("rst_ctrl_lo", ctrl_out[63:0], 64'h0);
    check("rst_ctrl_hi", ctrl_out[127:64], 64'h0);
    reset = 1'b0;
    check("rel_readies_same_cycle", {bus_if.awready, bus_if.wready, bus_if.arready}, 3'b000);
    tick();
    check("rel_readies_next_cycle", {bus_if.awready, bus_if.wready, bus_if.arready}, 3'b111);

    // Table-driven accesses
    for (int k = 0; k < 15; k++) begin
      if (tbl[k].wr) begin
        do_write(tbl[k].addr, tbl[k].data, tbl[k].strb, r);
        check($sformatf("vec%0d_bresp", k), r, tbl[k].resp);
      end else begin
        do_read(tbl[k].addr, d, r);
        check($sformatf("vec%0d_rresp", k), r, tbl[k].resp);
        check($sformatf("vec%0d_rdata", k), d, tbl[k].rdata);
      end
    end
    check("table_ctrl_out", ctrl_out, {32'hCAFE0000, 32'h00000000, 32'hDEADBEEF, 32'h11223344});

    // W arrives three cycles ahead of AW, partial strobe
    bus_if.wdata  = 32'hAABBCCDD;
    bus_if.wstrb  = 4'h5;
    bus_if.wvalid = 1'b1;
    check("skew_wready_pre", bus_if.wready, 1'b1);
    tick();
    bus_if.wvalid = 1'b0;
    check("skew_w_buffered", {bus_if.wready, bus_if.awready}, 2'b01);
    tick(); tick();
    check("skew_no_bvalid_yet", bus_if.bvalid, 1'b0);
    bus_if.awaddr  = 8'h00;
    bus_if.awvalid = 1'b1;
    tick();
    bus_if.awvalid = 1'b0;
    check("skew_bvalid", bus_if.bvalid, 1'b1);
    check("skew_bresp", bus_if.bresp, 2'b00);
    check("skew_reg0", reg_of(0), 32'h11BB33DD);
    bus_if.bready = 1'b1;
    tick();
    bus_if.bready = 1'b0;

    // Backpressure: write reg3 and read reg1 with bready/rready held low
    bus_if.awaddr = 8'h0C; bus_if.wdata = 32'h0BADF00D; bus_if.wstrb = 4'hF;
    bus_if.araddr = 8'h04;
    bus_if.awvalid = 1'b1; bus_if.wvalid = 1'b1; bus_if.arvalid = 1'b1;
    check("bp_readies_pre", {bus_if.awready, bus_if.wready, bus_if.arready}, 3'b111);
    tick();
    bus_if.awvalid = 1'b0; bus_if.wvalid = 1'b0; bus_if.arvalid = 1'b0;
    for (int c = 0; c < 5; c++) begin
      check($sformatf("bp_hold%0d_ctl", c),
            {bus_if.bvalid, bus_if.rvalid, bus_if.bresp, bus_if.rresp,
             bus_if.awready, bus_if.wready, bus_if.arready}, 9'b1_1_00_00_000);
      check($sformatf("bp_hold%0d_rdata", c), bus_if.rdata, 32'hDEADBEEF);
      tick();
    end
    bus_if.bready = 1'b1; bus_if.rready = 1'b1;
    tick();
    bus_if.bready = 1'b0; bus_if.rready = 1'b0;
    check("bp_release", {bus_if.bvalid, bus_if.rvalid, bus_if.awready, bus_if.wready, bus_if.arready},
          5'b00111);
    check("bp_reg3", reg_of(3), 32'h0BADF00D);

    // Same-edge write and read of reg2
    do_write(8'h08, 32'h00000012, 4'hF, r);
    check("col_setup_bresp", r, 2'b00);
    bus_if.awaddr = 8'h08; bus_if.wdata = 32'h00000055; bus_if.wstrb = 4'hF;
    bus_if.araddr = 8'h08;
    bus_if.awvalid = 1'b1; bus_if.wvalid = 1'b1; bus_if.arvalid = 1'b1;
    tick();
    bus_if.awvalid = 1'b0; bus_if.wvalid = 1'b0; bus_if.arvalid = 1'b0;
    check("col_rdata_old", bus_if.rdata, 32'h00000012);
    check("col_reg2_new", reg_of(2), 32'h00000055);
    bus_if.bready = 1'b1; bus_if.rready = 1'b1;
    tick();
    bus_if.bready = 1'b0; bus_if.rready = 1'b0;

    // Reset while in W_RESP and R_DATA
    bus_if.awaddr = 8'h04; bus_if.wdata = 32'h00000077; bus_if.wstrb = 4'hF;
    bus_if.araddr = 8'h00;
    bus_if.awvalid = 1'b1; bus_if.wvalid = 1'b1; bus_if.arvalid = 1'b1;
`ifdef AXI_LITE_REGFILE_WRITE_PULSE_EN
    check("pulse_before", ctrl_wr_pulse, 4'b0000);
`endif
    tick();
    bus_if.awvalid = 1'b0; bus_if.wvalid = 1'b0; bus_if.arvalid = 1'b0;
    check("mid_busy", {bus_if.bvalid, bus_if.rvalid}, 2'b11);
    check("mid_rdata", bus_if.rdata, 32'h11BB33DD);
    check("mid_reg1", reg_of(1), 32'h00000077);
`ifdef AXI_LITE_REGFILE_WRITE_PULSE_EN
    check("pulse_reg1", ctrl_wr_pulse, 4'b0010);
`endif
    reset = 1'b1;
    tick();
    check("mid_rst_valids", {bus_if.bvalid, bus_if.rvalid}, 2'b00);
    check("mid_rst_ctrl", ctrl_out, 128'h0);
    check("mid_rst_rdata", bus_if.rdata, 32'h0);
    check("mid_rst_readies", {bus_if.awready, bus_if.wready, bus_if.arready}, 3'b000);
`ifdef AXI_LITE_REGFILE_WRITE_PULSE_EN
    check("pulse_after", ctrl_wr_pulse, 4'b0000);
`endif
    reset = 1'b0;
    check("mid_rel_readies_low", {bus_if.awready, bus_if.wready, bus_if.arready}, 3'b000);
    tick();
    check("mid_rel_readies_high", {bus_if.awready, bus_if.wready, bus_if.arready}, 3'b111);
    check("mid_rel_valids", {bus_if.bvalid, bus_if.rvalid}, 2'b00);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
